// File: rtl/uart_loader.sv
// uart_loader: 8N1 UART receiver feeding a length-prefixed little-endian word loader that holds the CPU in reset.
// Optional trailing XOR checksum byte is enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_loader #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int MEM_BYTES = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RxD,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  output logic        cpu_hold,
  output logic        load_done,
`ifdef UART_LOADER_CHECKSUM_EN
  output logic        checksum_error,
`endif
  output logic        frame_error
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer; the extra stage gives the previous value for edge detect
  // ---------------------------------------------------------------------------
  logic rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
  logic start_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= RxD;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
    end
  end

  assign start_edge = rxd_prev_reg & ~rxd_sync_reg;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic             byte_valid_reg, byte_valid_next;
  logic [7:0]       byte_data_reg, byte_data_next;
  logic             frame_error_reg, frame_error_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg    <= RX_IDLE;
      rx_cnt_reg      <= '0;
      rx_bit_reg      <= '0;
      rx_shift_reg    <= '0;
      byte_valid_reg  <= 1'b0;
      byte_data_reg   <= '0;
      frame_error_reg <= 1'b0;
    end else begin
      rx_state_reg    <= rx_state_next;
      rx_cnt_reg      <= rx_cnt_next;
      rx_bit_reg      <= rx_bit_next;
      rx_shift_reg    <= rx_shift_next;
      byte_valid_reg  <= byte_valid_next;
      byte_data_reg   <= byte_data_next;
      frame_error_reg <= frame_error_next;
    end
  end

  always_comb begin
    rx_state_next    = rx_state_reg;
    rx_cnt_next      = rx_cnt_reg;
    rx_bit_next      = rx_bit_reg;
    rx_shift_next    = rx_shift_reg;
    byte_valid_next  = 1'b0;
    byte_data_next   = byte_data_reg;
    frame_error_next = frame_error_reg;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_next = '0;
        rx_bit_next = '0;
        if (start_edge) rx_state_next = RX_START;
      end
      RX_START: begin
        // Mid-start-bit check: a line already back high was only a glitch
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = rxd_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rxd_sync_reg, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 1'b1;
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = RX_IDLE;
          if (rxd_sync_reg) begin
            byte_valid_next = 1'b1;
            byte_data_next  = rx_shift_reg;
          end else begin
            frame_error_next = 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    LD_LEN_LO, LD_LEN_HI, LD_PAYLOAD, LD_CHECK, LD_DONE, LD_FAIL
  } ld_state_t;

  ld_state_t   ld_state_reg, ld_state_next;
  logic [15:0] len_reg, len_next;
  logic [15:0] idx_reg, idx_next;
  logic [31:0] word_buf_reg, word_buf_next;
  logic [31:0] mem_address_reg, mem_address_next;
  logic [31:0] mem_write_data_reg, mem_write_data_next;
  logic        mem_write_en_reg, mem_write_en_next;
  logic        load_done_reg, load_done_next;
  logic        cpu_hold_reg, cpu_hold_next;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  csum_reg, csum_next;
  logic        checksum_error_reg, checksum_error_next;
`endif

  logic [1:0]  lane;
  logic [31:0] assembled_word;
  logic [31:0] word_addr;
  logic        last_byte;
  logic        in_range;
  logic        finish;

  assign lane      = idx_reg[1:0];
  assign last_byte = (idx_reg == len_reg - 16'd1);
  assign word_addr = {16'h0000, idx_reg[15:2], 2'b00};
  assign in_range  = (word_addr < 32'(MEM_BYTES));

  // Lanes below the incoming one keep buffered bytes, lanes above read as zero
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign assembled_word[gi*8 +: 8] =
          (lane == 2'(gi)) ? byte_data_reg :
          ((2'(gi) < lane) ? word_buf_reg[gi*8 +: 8] : 8'h00);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state_reg       <= LD_LEN_LO;
      len_reg            <= '0;
      idx_reg            <= '0;
      word_buf_reg       <= '0;
      mem_address_reg    <= '0;
      mem_write_data_reg <= '0;
      mem_write_en_reg   <= 1'b0;
      load_done_reg      <= 1'b0;
      cpu_hold_reg       <= 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_reg           <= '0;
      checksum_error_reg <= 1'b0;
`endif
    end else begin
      ld_state_reg       <= ld_state_next;
      len_reg            <= len_next;
      idx_reg            <= idx_next;
      word_buf_reg       <= word_buf_next;
      mem_address_reg    <= mem_address_next;
      mem_write_data_reg <= mem_write_data_next;
      mem_write_en_reg   <= mem_write_en_next;
      load_done_reg      <= load_done_next;
      cpu_hold_reg       <= cpu_hold_next;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_reg           <= csum_next;
      checksum_error_reg <= checksum_error_next;
`endif
    end
  end

  always_comb begin
    ld_state_next       = ld_state_reg;
    len_next            = len_reg;
    idx_next            = idx_reg;
    word_buf_next       = word_buf_reg;
    mem_address_next    = mem_address_reg;
    mem_write_data_next = mem_write_data_reg;
    mem_write_en_next   = 1'b0;
    finish              = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_next           = csum_reg;
    checksum_error_next = checksum_error_reg;
`endif
    case (ld_state_reg)
      LD_LEN_LO: begin
        if (byte_valid_reg) begin
          len_next[7:0] = byte_data_reg;
          ld_state_next = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        if (byte_valid_reg) begin
          len_next[15:8] = byte_data_reg;
          idx_next       = '0;
          word_buf_next  = '0;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_next      = '0;
          if ({byte_data_reg, len_reg[7:0]} == 16'h0000) ld_state_next = LD_CHECK;
          else                                           ld_state_next = LD_PAYLOAD;
`else
          if ({byte_data_reg, len_reg[7:0]} == 16'h0000) begin
            ld_state_next = LD_DONE;
            finish        = 1'b1;
          end else begin
            ld_state_next = LD_PAYLOAD;
          end
`endif
        end
      end
      LD_PAYLOAD: begin
        if (byte_valid_reg) begin
          word_buf_next = assembled_word;
          idx_next      = idx_reg + 16'd1;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_next     = csum_reg ^ byte_data_reg;
`endif
          if (lane == 2'd3 || last_byte) begin
            // Bytes past the end of memory are still consumed, just not written
            if (in_range) begin
              mem_write_en_next   = 1'b1;
              mem_address_next    = word_addr;
              mem_write_data_next = assembled_word;
            end
          end
          if (last_byte) begin
`ifdef UART_LOADER_CHECKSUM_EN
            ld_state_next = LD_CHECK;
`else
            ld_state_next = LD_DONE;
`endif
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (byte_valid_reg) begin
          if (byte_data_reg == csum_reg) begin
            ld_state_next = LD_DONE;
            finish        = 1'b1;
          end else begin
            ld_state_next       = LD_FAIL;
            checksum_error_next = 1'b1;
          end
        end
      end
      LD_FAIL: ld_state_next = LD_FAIL;
`endif
      LD_DONE: ld_state_next = LD_DONE;
      default: ld_state_next = LD_LEN_LO;
    endcase
    // Entering DONE from PAYLOAD releases one cycle after the final strobe
    load_done_next = load_done_reg | finish | (ld_state_reg == LD_DONE);
    cpu_hold_next  = ~load_done_next;
  end

  assign mem_address    = mem_address_reg;
  assign mem_write_data = mem_write_data_reg;
  assign mem_write_en   = mem_write_en_reg;
  assign cpu_hold       = cpu_hold_reg;
  assign load_done      = load_done_reg;
  assign frame_error    = frame_error_reg;
`ifdef UART_LOADER_CHECKSUM_EN
  assign checksum_error = checksum_error_reg;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: 10 clocks per bit, 16-byte memory window, randomized payloads.
// Write expectations come from a word-packing model; a negedge monitor pops and compares each strobe.
`timescale 1ns/1ps
module tb_uart_loader;
  localparam int CLK_HZ    = 1_000_000;
  localparam int BAUD      = 100_000;
  localparam int CPB       = CLK_HZ / BAUD;
  localparam int MEM_BYTES = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RxD = 1'b1;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        cpu_hold;
  logic        load_done;
  logic        frame_error;
`ifdef UART_LOADER_CHECKSUM_EN
  logic        checksum_error;
`endif

  uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MEM_BYTES(MEM_BYTES)) dut (
    .clk           (clk),
    .reset         (reset),
    .RxD           (RxD),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_write_en  (mem_write_en),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
`ifdef UART_LOADER_CHECKSUM_EN
    .checksum_error(checksum_error),
`endif
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = -1;
  int done_cyc = -1;
  int last_start_cyc = 0;
  logic prev_en = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (mem_write_en) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      check("strobe_width", {31'b0, prev_en}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                 mem_address, mem_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", mem_address, mon_e.addr);
        check("wr_data", mem_write_data, mon_e.data);
      end
    end
    if (load_done && !prev_done) done_cyc = cyc;
    prev_en   = mem_write_en;
    prev_done = load_done;
  end

  // Reference model: pack payload little-endian into words, drop words past memory
  task automatic expect_words(input logic [7:0] pl[$], output int n_exp);
    int n = pl.size();
    n_exp = 0;
    for (int w = 0; w * 4 < n; w++) begin
      logic [31:0] d = 32'h0;
      for (int j = 0; j < 4; j++)
        if (w * 4 + j < n) d[j*8 +: 8] = pl[w*4 + j];
      if (w * 4 < MEM_BYTES) begin
        exp_q.push_back('{addr: 32'(w * 4), data: d});
        n_exp++;
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    RxD = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Called on a negedge; returns on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    last_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    if (!stop_bit) drive_bit(1'b1);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap_max);
    foreach (s[i]) begin
      send_byte(s[i], 1'b1);
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    strobe_cnt = 0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (load_done) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: load_done %0b after 40 cycles, expected 1", load_done);
    end
  endtask

  task automatic run_load(input string tag, input logic [7:0] pl[$], input int gap_max);
    int n = pl.size();
    int n_exp;
    int lat;
    int lo;
    logic [7:0] stream[$];
    logic [7:0] x = 8'h00;
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    foreach (pl[i]) begin
      stream.push_back(pl[i]);
      x ^= pl[i];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    stream.push_back(x);
    lo = 98;
`else
    lo = (n > 0) ? 99 : 98;
`endif
    expect_words(pl, n_exp);
    strobe_cnt      = 0;
    done_cyc        = -1;
    last_strobe_cyc = -1;
    send_stream(stream, gap_max);
    wait_done();
    check({tag, "_load_done"}, {31'b0, load_done}, 32'h1);
    check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'h0);
    check({tag, "_strobes"}, strobe_cnt, n_exp);
    check({tag, "_pending"}, exp_q.size(), 0);
    lat = done_cyc - last_start_cyc;
    checks++;
    if (lat < lo || lat > lo + 2) begin
      errors++;
      $display("FAIL %s_done_latency: got %0d cycles from last start bit, expected %0d..%0d",
               tag, lat, lo, lo + 2);
    end
`ifndef UART_LOADER_CHECKSUM_EN
    if (n > 0 && ((n - 1) / 4) * 4 < MEM_BYTES)
      check({tag, "_done_after_strobe"}, done_cyc - last_strobe_cyc, 1);
`endif
    $display("load %s: N=%0d strobes=%0d done_latency=%0d", tag, n, strobe_cnt, lat);
  endtask

  logic [7:0] q[$];
  logic [7:0] empty_q[$];

  initial begin
    int n_exp;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_address", mem_address, 32'h0);
    check("rst_data", mem_write_data, 32'h0);
    check("rst_en", {31'b0, mem_write_en}, 32'h0);
    check("rst_cpu_hold", {31'b0, cpu_hold}, 32'h1);
    check("rst_load_done", {31'b0, load_done}, 32'h0);
    check("rst_frame_error", {31'b0, frame_error}, 32'h0);
`ifdef UART_LOADER_CHECKSUM_EN
    check("rst_checksum_error", {31'b0, checksum_error}, 32'h0);
`endif

    // Five-byte payload, back-to-back frames
    q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_load("basic", q, 0);

    // Bytes after completion are ignored
    strobe_cnt = 0;
    q = {8'h04, 8'h00};
    send_stream(q, 0);
    repeat (5) @(negedge clk);
    check("post_done_strobes", strobe_cnt, 0);
    check("post_done_load_done", {31'b0, load_done}, 32'h1);

    // Empty payload
    do_reset();
    run_load("empty", empty_q, 0);

    // Bad stop bit is flagged and the byte dropped
    do_reset();
    send_byte(8'h03, 1'b0);
    check("frame_error_set", {31'b0, frame_error}, 32'h1);
    q = {8'hAA, 8'hBB};
    run_load("after_ferr", q, 2);
    check("frame_error_sticky", {31'b0, frame_error}, 32'h1);

    // Short low glitch on an idle line is not a start bit
    do_reset();
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_strobes", strobe_cnt, 0);
    check("glitch_frame_error", {31'b0, frame_error}, 32'h0);
    check("glitch_load_done", {31'b0, load_done}, 32'h0);
    q = {8'h7E};
    run_load("after_glitch", q, 0);

    // Reset mid-load and mid-byte, then a complete reload
    do_reset();
    q = {8'h04, 8'h00, 8'h01, 8'h02};
    send_stream(q, 0);
    RxD = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_strobes", strobe_cnt, 0);
    check("abort_cpu_hold", {31'b0, cpu_hold}, 32'h1);
    do_reset();
    q = {8'h01, 8'h02, 8'h03, 8'h04};
    run_load("reload", q, 0);

    // Payload crossing the end of memory: last word discarded
    do_reset();
    q.delete();
    for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
    run_load("mem_edge", q, 0);

    // Randomized payload lengths and inter-frame gaps
    for (int r = 0; r < 6; r++) begin
      do_reset();
      q.delete();
      for (int i = 0; i < int'($urandom_range(22, 1)); i++) q.push_back(8'($urandom));
      run_load($sformatf("rand%0d", r), q, (r % 2) * 3);
    end

`ifdef UART_LOADER_CHECKSUM_EN
    do_reset();
    q = {8'h0F, 8'hF0};
    run_load("csum_ok", q, 0);
    check("csum_ok_error", {31'b0, checksum_error}, 32'h0);

    do_reset();
    q = {8'h0F, 8'hF0};
    expect_words(q, n_exp);
    q = {8'h02, 8'h00, 8'h0F, 8'hF0, 8'h00};
    send_stream(q, 0);
    repeat (10) @(negedge clk);
    check("csum_bad_error", {31'b0, checksum_error}, 32'h1);
    check("csum_bad_cpu_hold", {31'b0, cpu_hold}, 32'h1);
    check("csum_bad_load_done", {31'b0, load_done}, 32'h0);
    check("csum_bad_strobes", strobe_cnt, n_exp);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
